// File: rtl/gate_vector_checker_pkg.sv
// Shared state encodings and standard 2-input truth tables for the gate
// vector checker family.
package gate_vector_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // TT[v] is the expected gate output for input vector v (v[1] = a, v[0] = b).
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/gate_vector_checker_settle_timer.sv
// Per-vector settle counter: counts WAIT cycles and flags when the gate
// has had SETTLE full cycles with a stable input vector.
module settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [3:0] LAST_COUNT = 4'(SETTLE - 1);

    logic [3:0] r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= 4'd0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign o_expired = (r_count == LAST_COUNT);

endmodule

// File: rtl/gate_vector_checker.sv
// Exhaustive stimulus/checker for a combinational gate: walks every N-bit
// vector, waits SETTLE cycles, samples i_dut_y and compares it against TT.
module gate_vector_checker
    import gate_vector_checker_pkg::*;
#(
    parameter int                 N      = 2,
    parameter logic [(1<<N)-1:0]  TT     = TT_AND2,
    parameter int                 SETTLE = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_dut_y,
    output logic [N-1:0] o_vec,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_pass,
    output logic [N:0]   o_err_cnt,
    output logic [N-1:0] o_first_err_vec,
    output logic         o_first_err_valid
);

    localparam logic [N-1:0] LAST_VEC = '1;

    state_t       r_state;
    state_t       w_next_state;
    logic [N-1:0] r_vec;
    logic [N:0]   r_err_cnt;
    logic [N-1:0] r_first_err_vec;
    logic         r_first_err_valid;

    logic w_load_start;
    logic w_check;
    logic w_advance;
    logic w_timer_clear;
    logic w_timer_en;
    logic w_expired;
    logic w_mismatch;

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_timer_clear),
        .i_enable  (w_timer_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state  = r_state;
        w_load_start  = 1'b0;
        w_check       = 1'b0;
        w_advance     = 1'b0;
        w_timer_clear = 1'b0;
        w_timer_en    = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_next_state  = ST_WAIT;
                    w_load_start  = 1'b1;
                    w_timer_clear = 1'b1;
                end
            end
            ST_WAIT: begin
                w_timer_en = 1'b1;
                if (w_expired) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_check = 1'b1;
                if (r_vec == LAST_VEC) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_advance     = 1'b1;
                    w_timer_clear = 1'b1;
                    w_next_state  = ST_WAIT;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_mismatch = w_check && (i_dut_y != TT[r_vec]);

    // Start clears results on the same edge it launches the run, so a
    // restart from DONE never shows stale results while busy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vec             <= '0;
            r_err_cnt         <= '0;
            r_first_err_vec   <= '0;
            r_first_err_valid <= 1'b0;
        end else if (w_load_start) begin
            r_vec             <= '0;
            r_err_cnt         <= '0;
            r_first_err_vec   <= '0;
            r_first_err_valid <= 1'b0;
        end else begin
            if (w_advance) begin
                r_vec <= r_vec + 1'b1;
            end
            if (w_mismatch) begin
                r_err_cnt <= r_err_cnt + 1'b1;
                if (!r_first_err_valid) begin
                    r_first_err_vec   <= r_vec;
                    r_first_err_valid <= 1'b1;
                end
            end
        end
    end

    assign o_vec             = r_vec;
    assign o_busy            = (r_state == ST_WAIT) || (r_state == ST_CHECK);
    assign o_done            = (r_state == ST_DONE);
    assign o_pass            = o_done && (r_err_cnt == '0);
    assign o_err_cnt         = r_err_cnt;
    assign o_first_err_vec   = r_first_err_vec;
    assign o_first_err_valid = r_first_err_valid;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Scoreboard bench: two checker instances (AND table and XOR table) driven
// by a behavioural gate model; expected vectors/results queued per run.
module tb_gate_vector_checker;
    import gate_vector_checker_pkg::*;

    typedef struct packed {
        logic [2:0] err_cnt;
        logic [1:0] fev;
        logic       fevld;
        logic       pass;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_x = 1'b0;
    int   mode = 0;
    int   sel = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    logic [1:0] vec_a, vec_x, fev_a, fev_x, s_vec, s_fev;
    logic [2:0] err_a, err_x, s_err;
    logic busy_a, busy_x, done_a, done_x, pass_a, pass_x, fvl_a, fvl_x;
    logic s_busy, s_done, s_pass, s_fvl;
    logic y_a, y_x;

    logic [1:0] vec_q[$];
    res_t       res_q[$];

    always #5 clk = ~clk;

    // mode 0: working AND gate, 1: output stuck at 0, 2: output stuck at 1
    function automatic logic gate(input int m, input logic [1:0] v);
        case (m)
            0:       return v[1] & v[0];
            1:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign y_a = gate(mode, vec_a);
    assign y_x = vec_x[1] & vec_x[0];

    gate_vector_checker #(.N(2), .TT(TT_AND2), .SETTLE(2)) u_and (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_dut_y(y_a),
        .o_vec(vec_a), .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a),
        .o_err_cnt(err_a), .o_first_err_vec(fev_a), .o_first_err_valid(fvl_a)
    );

    gate_vector_checker #(.N(2), .TT(TT_XOR2), .SETTLE(2)) u_xor (
        .i_clk(clk), .i_rst(rst), .i_start(start_x), .i_dut_y(y_x),
        .o_vec(vec_x), .o_busy(busy_x), .o_done(done_x), .o_pass(pass_x),
        .o_err_cnt(err_x), .o_first_err_vec(fev_x), .o_first_err_valid(fvl_x)
    );

    always_comb begin
        if (sel == 1) begin
            s_vec = vec_x; s_busy = busy_x; s_done = done_x; s_pass = pass_x;
            s_err = err_x; s_fev = fev_x; s_fvl = fvl_x;
        end else begin
            s_vec = vec_a; s_busy = busy_a; s_done = done_a; s_pass = pass_a;
            s_err = err_a; s_fev = fev_a; s_fvl = fvl_a;
        end
    end

    task automatic set_start(input logic val);
        if (sel == 1) start_x = val;
        else          start_a = val;
    endtask

    task automatic expect_reset_values(input string tag);
        n_vec++;
        if ({s_vec, s_busy, s_done, s_pass, s_err, s_fev, s_fvl} !== 11'd0) begin
            n_miss++;
            $display("FAIL %s: vec=%0d busy=%0b done=%0b pass=%0b err=%0d fev=%0d fvl=%0b, want all zero",
                     tag, s_vec, s_busy, s_done, s_pass, s_err, s_fev, s_fvl);
        end
    endtask

    // Launch a run, follow it cycle by cycle against the queued vectors and
    // check the queued result when done must rise (12 cycles after start).
    task automatic run(input int s, input int m, input int repulse_at);
        res_t       exp_r, got_r;
        logic [3:0] tt;
        logic [1:0] v;
        logic [1:0] exp_v;
        logic       y;
        sel  = s;
        mode = m;
        tt   = (s == 1) ? TT_XOR2 : TT_AND2;
        exp_r = '0;
        for (int i = 0; i < 4; i++) begin
            v = i[1:0];
            y = (s == 1) ? (v[1] & v[0]) : gate(m, v);
            if (y !== tt[i]) begin
                exp_r.err_cnt = exp_r.err_cnt + 3'd1;
                if (!exp_r.fevld) begin
                    exp_r.fev   = v;
                    exp_r.fevld = 1'b1;
                end
            end
            for (int r = 0; r < 3; r++) vec_q.push_back(v);
        end
        exp_r.pass = (exp_r.err_cnt == 3'd0);
        res_q.push_back(exp_r);

        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        for (int t = 0; t < 12; t++) begin
            set_start(1'b0);
            exp_v = vec_q.pop_front();
            n_vec++;
            if (s_vec !== exp_v || s_busy !== 1'b1 || s_done !== 1'b0) begin
                n_miss++;
                $display("FAIL run_cycle t=%0d: vec=%0d busy=%0b done=%0b, want vec=%0d busy=1 done=0",
                         t, s_vec, s_busy, s_done, exp_v);
            end
            if (t == 0) begin
                n_vec++;
                if (s_err !== 3'd0 || s_fvl !== 1'b0) begin
                    n_miss++;
                    $display("FAIL start_clear: err=%0d fvl=%0b, want 0 0", s_err, s_fvl);
                end
            end
            if (t == repulse_at) set_start(1'b1);
            @(negedge clk);
        end
        set_start(1'b0);
        n_vec++;
        if (s_done !== 1'b1 || s_busy !== 1'b0 || s_vec !== 2'd3) begin
            n_miss++;
            $display("FAIL done_timing: done=%0b busy=%0b vec=%0d, want 1 0 3", s_done, s_busy, s_vec);
        end
        exp_r = res_q.pop_front();
        got_r = '{err_cnt: s_err, fev: s_fev, fevld: s_fvl, pass: s_pass};
        n_vec++;
        if (got_r !== exp_r) begin
            n_miss++;
            $display("FAIL result: err=%0d fev=%0d fvl=%0b pass=%0b, want err=%0d fev=%0d fvl=%0b pass=%0b",
                     got_r.err_cnt, got_r.fev, got_r.fevld, got_r.pass,
                     exp_r.err_cnt, exp_r.fev, exp_r.fevld, exp_r.pass);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        sel = 0;
        expect_reset_values("reset_and");
        sel = 1;
        expect_reset_values("reset_xor");
        rst = 1'b0;
        @(negedge clk);
        sel = 0;
        expect_reset_values("idle_hold");
    endtask

    task automatic test_and_pass();     run(0, 0, -1); endtask
    task automatic test_stuck0();       run(0, 1, -1); endtask
    task automatic test_stuck1();       run(0, 2, -1); endtask
    task automatic test_xor_table();    run(1, 0, -1); endtask
    task automatic test_repulse_busy(); run(0, 0, 5);  endtask

    task automatic test_back_to_back();
        run(0, 2, -1);
        run(0, 0, -1);
    endtask

    task automatic test_mid_run_reset();
        sel  = 0;
        mode = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expect_reset_values("mid_run_reset");
        rst = 1'b0;
        @(negedge clk);
        expect_reset_values("after_reset_idle");
        vec_q.delete();
        res_q.delete();
        run(0, 0, -1);
    endtask

    initial begin
        test_reset();
        test_and_pass();
        test_stuck0();
        test_stuck1();
        test_xor_table();
        test_repulse_busy();
        test_back_to_back();
        test_mid_run_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
